// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative multiplier/divider: latches operand magnitudes,
// drives the unit handshake, sign-corrects the raw result and returns HI/LO.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        mult_valid,
    output logic        div_valid,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        mult_done,
    input  logic [63:0] mult_c,
    input  logic        div_done,
    input  logic [63:0] div_c,
    output logic        resp_valid,
    output logic [31:0] resp_hi,
    output logic [31:0] resp_lo,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RUN_MUL, RUN_DIV, DZERO, RESP} state_t;

    state_t state, state_nx;
    logic   sign_a, sign_b;
    logic   accept, op_signed, op_div;
    logic   in_sign_a, in_sign_b;
    logic   neg_res;
    logic   mul_fin, div_fin, dz_fin;
    logic [63:0] prod;
    logic [31:0] quo, rem, dz_hi;

    assign op_signed = req_op[0];
    assign op_div    = req_op[1];
    assign accept    = req_valid && (state == IDLE) && !flush;
    assign in_sign_a = req_a[31] && op_signed;
    assign in_sign_b = req_b[31] && op_signed;

    assign neg_res = sign_a ^ sign_b;
    assign prod    = neg_res ? -mult_c : mult_c;
    assign quo     = neg_res ? -div_c[31:0] : div_c[31:0];
    assign rem     = sign_a ? -div_c[63:32] : div_c[63:32];
    // unit_a holds the dividend magnitude; re-apply its sign to recover the original
    assign dz_hi   = sign_a ? -unit_a : unit_a;

    assign mul_fin = (state == RUN_MUL) && mult_done && !flush;
    assign div_fin = (state == RUN_DIV) && div_done && !flush;
    assign dz_fin  = (state == DZERO) && !flush;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = (state == IDLE);
        busy       = (state != IDLE);
        mult_valid = (state == RUN_MUL);
        div_valid  = (state == RUN_DIV);
        resp_valid = (state == RESP);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!op_div)            state_nx = RUN_MUL;
                    else if (req_b == '0)   state_nx = DZERO;
                    else                    state_nx = RUN_DIV;
                end
            end
            RUN_MUL: if (mult_done) state_nx = RESP;
            RUN_DIV: if (div_done)  state_nx = RESP;
            DZERO:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            unit_a  <= '0;
            unit_b  <= '0;
            resp_hi <= '0;
            resp_lo <= '0;
        end else begin
            if (accept) begin
                sign_a <= in_sign_a;
                sign_b <= in_sign_b;
                unit_a <= in_sign_a ? -req_a : req_a;
                unit_b <= in_sign_b ? -req_b : req_b;
            end
            if (mul_fin) begin
                resp_hi <= prod[63:32];
                resp_lo <= prod[31:0];
            end
            if (div_fin) begin
                resp_hi <= rem;
                resp_lo <= quo;
            end
            if (dz_fin) begin
                resp_hi <= dz_hi;
                resp_lo <= 32'hFFFF_FFFF;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: the bench plays the multiplier/divider and
// checks handshake timing, sign correction, divide-by-zero and flush behaviour.
module tb_muldiv_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        mult_valid;
    logic        div_valid;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        mult_done;
    logic [63:0] mult_c;
    logic        div_done;
    logic [63:0] div_c;
    logic        resp_valid;
    logic [31:0] resp_hi;
    logic [31:0] resp_lo;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
        .mult_valid(mult_valid), .div_valid(div_valid), .unit_a(unit_a), .unit_b(unit_b),
        .mult_done(mult_done), .mult_c(mult_c), .div_done(div_done), .div_c(div_c),
        .resp_valid(resp_valid), .resp_hi(resp_hi), .resp_lo(resp_lo), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; it is accepted at the next edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: got %0b exp 1", req_ready); end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++; if (req_ready !== 1'b1)  begin errors++; $display("FAIL rst_ready: got %0b exp 1", req_ready); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %0b exp 0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0b exp 0", resp_valid); end
        checks++; if (mult_valid !== 1'b0 || div_valid !== 1'b0) begin errors++; $display("FAIL rst_unit_valid: got %0b/%0b exp 0/0", mult_valid, div_valid); end
        checks++; if (resp_hi !== 32'h0 || resp_lo !== 32'h0) begin errors++; $display("FAIL rst_resp: got %h/%h exp 0/0", resp_hi, resp_lo); end
        checks++; if (unit_a !== 32'h0 || unit_b !== 32'h0) begin errors++; $display("FAIL rst_unit_ab: got %h/%h exp 0/0", unit_a, unit_b); end
    endtask

    task automatic test_mult_signed();
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        checks++; if (unit_a !== 32'd3 || unit_b !== 32'd5) begin errors++; $display("FAIL mult_mag: got %h/%h exp 3/5", unit_a, unit_b); end
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL mult_busy: got busy %0b ready %0b exp 1/0", busy, req_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mult_valid !== 1'b1 || div_valid !== 1'b0) begin errors++; $display("FAIL mult_valid_hold%0d: got %0b/%0b exp 1/0", i, mult_valid, div_valid); end
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mult_early_resp%0d: got %0b exp 0", i, resp_valid); end
            step();
        end
        mult_done = 1'b1; mult_c = 64'd15;
        checks++; if (mult_valid !== 1'b1) begin errors++; $display("FAIL mult_valid_at_done: got %0b exp 1", mult_valid); end
        step();
        mult_done = 1'b0; mult_c = 64'h0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL mult_resp_valid: got %0b exp 1", resp_valid); end
        checks++; if (resp_hi !== 32'hFFFF_FFFF || resp_lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_result: got %h_%h exp ffffffff_fffffff1", resp_hi, resp_lo); end
        checks++; if (mult_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mult_resp_state: got mv %0b ready %0b exp 0/0", mult_valid, req_ready); end
        step();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mult_back_idle: got rv %0b ready %0b busy %0b exp 0/1/0", resp_valid, req_ready, busy); end
        checks++; if (resp_hi !== 32'hFFFF_FFFF || resp_lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_hold: got %h_%h exp ffffffff_fffffff1", resp_hi, resp_lo); end
    endtask

    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_ua, input logic [31:0] exp_ub,
                           input logic [63:0] c, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input string name);
        issue(op, a, b);
        checks++; if (div_valid !== 1'b1 || mult_valid !== 1'b0) begin errors++; $display("FAIL %s_valid: got dv %0b mv %0b exp 1/0", name, div_valid, mult_valid); end
        checks++; if (unit_a !== exp_ua || unit_b !== exp_ub) begin errors++; $display("FAIL %s_mag: got %h/%h exp %h/%h", name, unit_a, unit_b, exp_ua, exp_ub); end
        step();
        div_done = 1'b1; div_c = c;
        step();
        div_done = 1'b0; div_c = 64'h0;
        checks++; if (resp_valid !== 1'b1 || div_valid !== 1'b0) begin errors++; $display("FAIL %s_resp_valid: got rv %0b dv %0b exp 1/0", name, resp_valid, div_valid); end
        checks++; if (resp_hi !== exp_hi || resp_lo !== exp_lo) begin errors++; $display("FAIL %s_result: got %h/%h exp %h/%h", name, resp_hi, resp_lo, exp_hi, exp_lo); end
        step();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL %s_idle: got ready %0b rv %0b exp 1/0", name, req_ready, resp_valid); end
    endtask

    task automatic test_div();
        run_div(OP_DIVU, 32'd7, 32'd2, 32'd7, 32'd2, {32'd1, 32'd3}, 32'd1, 32'd3, "divu");
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2, {32'd1, 32'd3}, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        // remainder follows dividend sign only: 7 / -2 -> q=-3, r=+1
        run_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2, {32'd1, 32'd3}, 32'd1, 32'hFFFF_FFFD, "div_negb");
        run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, {32'd0, 32'h8000_0000}, 32'h0, 32'h8000_0000, "div_ovf");
    endtask

    task automatic run_dzero(input logic [1:0] op, input logic [31:0] a, input logic [31:0] exp_hi, input string name);
        issue(op, a, 32'h0);
        checks++; if (div_valid !== 1'b0 || busy !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL %s_n1: got dv %0b busy %0b rv %0b exp 0/1/0", name, div_valid, busy, resp_valid); end
        step();
        checks++; if (resp_valid !== 1'b1 || div_valid !== 1'b0) begin errors++; $display("FAIL %s_n2: got rv %0b dv %0b exp 1/0", name, resp_valid, div_valid); end
        checks++; if (resp_hi !== exp_hi || resp_lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL %s_result: got %h/%h exp %h/ffffffff", name, resp_hi, resp_lo, exp_hi); end
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_idle: got %0b exp 1", name, req_ready); end
    endtask

    task automatic test_div_zero();
        run_dzero(OP_DIVU, 32'h1234_5678, 32'h1234_5678, "dz_u");
        run_dzero(OP_DIV, 32'hFFFF_FFFB, 32'hFFFF_FFFB, "dz_s");
    endtask

    task automatic test_flush_mult();
        issue(OP_MULTU, 32'd3, 32'd4);
        checks++; if (mult_valid !== 1'b1) begin errors++; $display("FAIL fl_run1: got %0b exp 1", mult_valid); end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (mult_valid !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL fl_abort: got mv %0b rv %0b exp 0/0", mult_valid, resp_valid); end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fl_idle: got ready %0b busy %0b exp 1/0", req_ready, busy); end
        issue(OP_MULTU, 32'd6, 32'd7);
        checks++; if (unit_a !== 32'd6 || unit_b !== 32'd7 || mult_valid !== 1'b1) begin errors++; $display("FAIL fl_new_issue: got %h/%h mv %0b exp 6/7/1", unit_a, unit_b, mult_valid); end
        mult_done = 1'b1; mult_c = 64'd42;
        step();
        mult_done = 1'b0; mult_c = 64'h0;
        checks++; if (resp_valid !== 1'b1 || resp_hi !== 32'h0 || resp_lo !== 32'd42) begin errors++; $display("FAIL fl_new_result: got rv %0b %h/%h exp 1/0/2a", resp_valid, resp_hi, resp_lo); end
        step();
    endtask

    task automatic test_flush_coincident();
        issue(OP_MULTU, 32'd2, 32'd3);
        mult_done = 1'b1; mult_c = 64'd6; flush = 1'b1;
        step();
        mult_done = 1'b0; mult_c = 64'h0; flush = 1'b0;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flc_done_drop: got rv %0b busy %0b exp 0/0", resp_valid, busy); end
        checks++; if (resp_hi !== 32'h0 || resp_lo !== 32'd42) begin errors++; $display("FAIL flc_resp_kept: got %h/%h exp 0/2a", resp_hi, resp_lo); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flc_no_late_resp: got %0b exp 0", resp_valid); end
        req_valid = 1'b1; req_op = OP_MULTU; req_a = 32'd9; req_b = 32'd9; flush = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flc_ready: got %0b exp 1", req_ready); end
        step();
        req_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || mult_valid !== 1'b0) begin errors++; $display("FAIL flc_no_accept: got busy %0b mv %0b exp 0/0", busy, mult_valid); end
        checks++; if (unit_a !== 32'd2 || unit_b !== 32'd3) begin errors++; $display("FAIL flc_no_latch: got %h/%h exp 2/3", unit_a, unit_b); end
    endtask

    task automatic test_idle_done();
        mult_done = 1'b1; mult_c = 64'hDEAD_BEEF_0000_0001;
        div_done = 1'b1; div_c = 64'h1111_2222_3333_4444;
        step();
        mult_done = 1'b0; div_done = 1'b0; mult_c = 64'h0; div_c = 64'h0;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_done: got rv %0b busy %0b exp 0/0", resp_valid, busy); end
        checks++; if (resp_hi !== 32'h0 || resp_lo !== 32'd42) begin errors++; $display("FAIL idle_done_resp: got %h/%h exp 0/2a", resp_hi, resp_lo); end
    endtask

    task automatic test_back_to_back();
        // request held valid throughout; the second must not enter until IDLE
        req_valid = 1'b1; req_op = OP_MULTU; req_a = 32'd1; req_b = 32'd2;
        step();
        req_a = 32'd10; req_b = 32'd10;
        mult_done = 1'b1; mult_c = 64'd2;
        step();
        mult_done = 1'b0; mult_c = 64'h0;
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_lo !== 32'd2) begin errors++; $display("FAIL b2b_resp1: got rv %0b ready %0b lo %h exp 1/0/2", resp_valid, req_ready, resp_lo); end
        step();
        checks++; if (req_ready !== 1'b1 || mult_valid !== 1'b0 || unit_a !== 32'd1) begin errors++; $display("FAIL b2b_gap: got ready %0b mv %0b ua %h exp 1/0/1", req_ready, mult_valid, unit_a); end
        step();
        req_valid = 1'b0;
        checks++; if (mult_valid !== 1'b1 || unit_a !== 32'd10 || unit_b !== 32'd10) begin errors++; $display("FAIL b2b_second: got mv %0b %h/%h exp 1/a/a", mult_valid, unit_a, unit_b); end
        mult_done = 1'b1; mult_c = 64'd100;
        step();
        mult_done = 1'b0; mult_c = 64'h0;
        checks++; if (resp_valid !== 1'b1 || resp_lo !== 32'd100 || resp_hi !== 32'h0) begin errors++; $display("FAIL b2b_resp2: got rv %0b %h/%h exp 1/0/64", resp_valid, resp_hi, resp_lo); end
        step();
    endtask

    task automatic test_reset_mid();
        issue(OP_DIV, 32'hFFFF_FFF0, 32'd3);
        checks++; if (div_valid !== 1'b1) begin errors++; $display("FAIL rm_run: got %0b exp 1", div_valid); end
        reset = 1'b1; div_done = 1'b1; div_c = 64'h5;
        step();
        reset = 1'b0; div_done = 1'b0; div_c = 64'h0;
        checks++; if (busy !== 1'b0 || div_valid !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rm_state: got busy %0b dv %0b rv %0b exp 0/0/0", busy, div_valid, resp_valid); end
        checks++; if (resp_hi !== 32'h0 || resp_lo !== 32'h0 || unit_a !== 32'h0 || unit_b !== 32'h0) begin errors++; $display("FAIL rm_clear: got %h/%h %h/%h exp all 0", resp_hi, resp_lo, unit_a, unit_b); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; flush = 1'b0;
        mult_done = 1'b0; mult_c = '0; div_done = 1'b0; div_c = '0;
        #1;
        test_reset();
        test_mult_signed();
        test_div();
        test_div_zero();
        test_flush_mult();
        test_flush_coincident();
        test_idle_done();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
